// File: rtl/pc_sequencer_pkg.sv
// Shared encodings for the PC sequencer: jump mux selects, FSM states and flush-length bounds.
package pc_sequencer_pkg;

  typedef logic [1:0] sel_t;
  typedef logic [1:0] state_t;

  localparam sel_t SEL_SEQ = 2'b00;
  localparam sel_t SEL_BR  = 2'b01;
  localparam sel_t SEL_J   = 2'b10;
  localparam sel_t SEL_JR  = 2'b11;

  localparam state_t StRun   = 2'd0;
  localparam state_t StStall = 2'd1;
  localparam state_t StFlush = 2'd2;
  localparam state_t StHalt  = 2'd3;

  localparam int unsigned FLUSH_CYCLES_MIN = 1;
  localparam int unsigned FLUSH_CYCLES_MAX = 7;

  // Counter preload: the FLUSH state itself accounts for the final cycle.
  function automatic logic [2:0] flush_load(input int unsigned cycles);
    int unsigned c;
    c = cycles;
    if (c < FLUSH_CYCLES_MIN) c = FLUSH_CYCLES_MIN;
    if (c > FLUSH_CYCLES_MAX) c = FLUSH_CYCLES_MAX;
    return 3'(c - 1);
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Redirect request / fetch PC bundle between decode-execute, the sequencer and fetch.
interface pc_sequencer_if;

  logic        stall;
  logic        halt;
  logic [31:0] req_pc;
  logic        br_en;
  logic        br_taken;
  logic [15:0] br_off;
  logic        j_en;
  logic [25:0] j_imm;
  logic        jr_en;
  logic [31:0] jr_addr;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;
  logic [1:0]  jump_mux_sel;
  logic        flush;
  logic        fetch_valid;
  logic        addr_err;
  logic        halted;

  modport master (
    output stall, halt, req_pc, br_en, br_taken, br_off, j_en, j_imm, jr_en, jr_addr,
    input  pc_out, pc_plus4, jump_mux_sel, flush, fetch_valid, addr_err, halted
  );

  modport slave (
    input  stall, halt, req_pc, br_en, br_taken, br_off, j_en, j_imm, jr_en, jr_addr,
    output pc_out, pc_plus4, jump_mux_sel, flush, fetch_valid, addr_err, halted
  );

endinterface

// File: rtl/pc_sequencer_next_pc_target.sv
// Redirect priority select (jr > j > taken branch) and the three redirect target adders.
module pc_sequencer_next_pc_target
  import pc_sequencer_pkg::*;
(
  input  logic [31:0] req_pc_i,
  input  logic        br_en_i,
  input  logic        br_taken_i,
  input  logic [15:0] br_off_i,
  input  logic        j_en_i,
  input  logic [25:0] j_imm_i,
  input  logic        jr_en_i,
  input  logic [31:0] jr_addr_i,
  output sel_t        sel_o,
  output logic [31:0] target_o,
  output logic        redirect_o,
  output logic        misalign_o
);

  logic [31:0] req_plus4;
  logic [31:0] br_tgt;
  logic [31:0] j_tgt;
  logic [31:0] jr_tgt;

  assign req_plus4 = req_pc_i + 32'd4;
  assign br_tgt    = req_plus4 + {{14{br_off_i[15]}}, br_off_i, 2'b00};
  assign j_tgt     = {req_plus4[31:28], j_imm_i, 2'b00};
  assign jr_tgt    = {jr_addr_i[31:2], 2'b00};

  always_comb begin
    sel_o    = SEL_SEQ;
    target_o = '0;
    if (jr_en_i) begin
      sel_o    = SEL_JR;
      target_o = jr_tgt;
    end else if (j_en_i) begin
      sel_o    = SEL_J;
      target_o = j_tgt;
    end else if (br_en_i && br_taken_i) begin
      sel_o    = SEL_BR;
      target_o = br_tgt;
    end
  end

  assign redirect_o = (sel_o != SEL_SEQ);
  assign misalign_o = jr_en_i && (jr_addr_i[1:0] != 2'b00);

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC register with RUN/STALL/FLUSH/HALT sequencing and a programmable flush window.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  logic               clk,
  input  logic               rst,
  pc_sequencer_if.slave      bus
);

  localparam logic [2:0] FlushLoad = flush_load(FLUSH_CYCLES);

  logic [31:0] pc_q, pc_d;
  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        fv_q, fv_d;

  sel_t        raw_sel;
  logic [31:0] target;
  logic        raw_redirect;
  logic        misalign;
  logic        accept;
  logic        redirect;

  pc_sequencer_next_pc_target u_next_pc_target (
    .req_pc_i   (bus.req_pc),
    .br_en_i    (bus.br_en),
    .br_taken_i (bus.br_taken),
    .br_off_i   (bus.br_off),
    .j_en_i     (bus.j_en),
    .j_imm_i    (bus.j_imm),
    .jr_en_i    (bus.jr_en),
    .jr_addr_i  (bus.jr_addr),
    .sel_o      (raw_sel),
    .target_o   (target),
    .redirect_o (raw_redirect),
    .misalign_o (misalign)
  );

  // HALT and reset swallow every request, including its select and error pulse.
  assign accept   = !rst && (state_q != StHalt);
  assign redirect = accept && raw_redirect;

  always_comb begin
    pc_d    = pc_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    fv_d    = fv_q;
    if (state_q == StHalt) begin
      fv_d = 1'b0;
    end else begin
      if (redirect) begin
        pc_d    = target;
        state_d = StFlush;
        cnt_d   = FlushLoad;
        fv_d    = 1'b0;
      end else if (state_q == StFlush) begin
        fv_d = 1'b0;
        if (cnt_q != 3'd0) begin
          cnt_d = cnt_q - 3'd1;
        end else begin
          state_d = bus.stall ? StStall : StRun;
          fv_d    = !bus.stall;
        end
      end else if (bus.stall) begin
        state_d = StStall;
      end else if (state_q == StStall) begin
        state_d = StRun;
        fv_d    = 1'b1;
      end else begin
        pc_d    = pc_q + 32'd4;
        state_d = StRun;
        fv_d    = 1'b1;
      end
      // Halt takes the state but a concurrent redirect still lands its target.
      if (bus.halt) begin
        state_d = StHalt;
        fv_d    = 1'b0;
        if (!redirect) pc_d = pc_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      state_q <= StRun;
      cnt_q   <= 3'd0;
      fv_q    <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fv_q    <= fv_d;
    end
  end

  assign bus.pc_out       = pc_q;
  assign bus.pc_plus4     = pc_q + 32'd4;
  assign bus.jump_mux_sel = accept ? raw_sel : SEL_SEQ;
  assign bus.flush        = (state_q == StFlush);
  assign bus.fetch_valid  = fv_q;
  assign bus.addr_err     = accept && misalign;
  assign bus.halted       = (state_q == StHalt);

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed vector bench for pc_sequencer with a two-cycle flush window.
module tb_pc_sequencer;
  import pc_sequencer_pkg::*;

  localparam int unsigned FlushCycles = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pc_sequencer_if bus ();

  pc_sequencer #(
    .RESET_PC     (32'h0000_0000),
    .FLUSH_CYCLES (FlushCycles)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        rst, stall, halt;
    logic [31:0] req_pc;
    logic        br_en, br_taken;
    logic [15:0] br_off;
    logic        j_en;
    logic [25:0] j_imm;
    logic        jr_en;
    logic [31:0] jr_addr;
    logic [1:0]  sel;
    logic        aerr;
    logic [31:0] pc;
    logic        fl, fv, h;
  } vec_t;

  vec_t vq[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic rst_v, stall_v, halt_v, input logic [31:0] req_pc_v,
    input logic br_en_v, br_taken_v, input logic [15:0] br_off_v,
    input logic j_en_v, input logic [25:0] j_imm_v, input logic jr_en_v,
    input logic [31:0] jr_addr_v, input logic [1:0] sel_v, input logic aerr_v,
    input logic [31:0] pc_v, input logic fl_v, fv_v, h_v);
    vec_t v;
    v.rst = rst_v;  v.stall = stall_v;  v.halt = halt_v;  v.req_pc = req_pc_v;
    v.br_en = br_en_v;  v.br_taken = br_taken_v;  v.br_off = br_off_v;
    v.j_en = j_en_v;  v.j_imm = j_imm_v;  v.jr_en = jr_en_v;  v.jr_addr = jr_addr_v;
    v.sel = sel_v;  v.aerr = aerr_v;  v.pc = pc_v;  v.fl = fl_v;  v.fv = fv_v;  v.h = h_v;
    return v;
  endfunction

  task automatic idle(input logic [31:0] pc, input logic fl, input logic fv);
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 16'h0, 0, 26'h0, 0, 0, SEL_SEQ, 0, pc, fl, fv, 0));
  endtask

  task automatic stall_idle(input logic [31:0] pc, input logic fl, input logic fv);
    vq.push_back(mk(0, 1, 0, 0, 0, 0, 16'h0, 0, 26'h0, 0, 0, SEL_SEQ, 0, pc, fl, fv, 0));
  endtask

  // Drive, check combinational outputs mid-cycle, then registered outputs after the edge.
  task automatic run_vec(input vec_t v, input string tag);
    rst          = v.rst;
    bus.stall    = v.stall;
    bus.halt     = v.halt;
    bus.req_pc   = v.req_pc;
    bus.br_en    = v.br_en;
    bus.br_taken = v.br_taken;
    bus.br_off   = v.br_off;
    bus.j_en     = v.j_en;
    bus.j_imm    = v.j_imm;
    bus.jr_en    = v.jr_en;
    bus.jr_addr  = v.jr_addr;
    #2;
    chk({tag, " sel"}, 32'(bus.jump_mux_sel), 32'(v.sel));
    chk({tag, " addr_err"}, 32'(bus.addr_err), 32'(v.aerr));
    @(posedge clk);
    #1;
    chk({tag, " pc_out"}, bus.pc_out, v.pc);
    chk({tag, " pc_plus4"}, bus.pc_plus4, v.pc + 32'd4);
    chk({tag, " flush"}, 32'(bus.flush), 32'(v.fl));
    chk({tag, " fetch_valid"}, 32'(bus.fetch_valid), 32'(v.fv));
    chk({tag, " halted"}, 32'(bus.halted), 32'(v.h));
  endtask

  initial begin
    // Reset then sequential fetch.
    vq.push_back(mk(1, 0, 0, 0, 0, 0, 16'h0, 0, 26'h0, 0, 0, SEL_SEQ, 0, 32'h0, 0, 0, 0));
    vq.push_back(mk(1, 0, 0, 0, 0, 0, 16'h0, 0, 26'h0, 0, 0, SEL_SEQ, 0, 32'h0, 0, 0, 0));
    idle(32'h4, 0, 1);  idle(32'h8, 0, 1);  idle(32'hC, 0, 1);  idle(32'h10, 0, 1);
    // Absolute jump, two-cycle flush.
    vq.push_back(mk(0, 0, 0, 32'h0040_0010, 0, 0, 16'h0, 1, 26'h100, 0, 0,
                    SEL_J, 0, 32'h400, 1, 0, 0));
    idle(32'h400, 1, 0);  idle(32'h400, 0, 1);  idle(32'h404, 0, 1);
    // Taken branch self-loop, then not taken.
    vq.push_back(mk(0, 0, 0, 32'h20, 1, 1, 16'hFFFF, 0, 26'h0, 0, 0,
                    SEL_BR, 0, 32'h20, 1, 0, 0));
    idle(32'h20, 1, 0);  idle(32'h20, 0, 1);
    vq.push_back(mk(0, 0, 0, 32'h20, 1, 0, 16'hFFFF, 0, 26'h0, 0, 0,
                    SEL_SEQ, 0, 32'h24, 0, 1, 0));
    // All three redirects at once, misaligned JR.
    vq.push_back(mk(0, 0, 0, 32'h0040_0010, 1, 1, 16'hFFFF, 1, 26'h100, 1, 32'h1003,
                    SEL_JR, 1, 32'h1000, 1, 0, 0));
    idle(32'h1000, 1, 0);  idle(32'h1000, 0, 1);  idle(32'h1004, 0, 1);
    // Jump accepted under stall, STALL after the flush window.
    stall_idle(32'h1004, 0, 1);
    vq.push_back(mk(0, 1, 0, 32'h0040_0010, 0, 0, 16'h0, 1, 26'h100, 0, 0,
                    SEL_J, 0, 32'h400, 1, 0, 0));
    stall_idle(32'h400, 1, 0);  stall_idle(32'h400, 0, 0);
    idle(32'h400, 0, 1);  idle(32'h404, 0, 1);
    // Redirect inside FLUSH reloads the counter; newest target wins.
    vq.push_back(mk(0, 0, 0, 32'h0, 0, 0, 16'h0, 1, 26'h200, 0, 0,
                    SEL_J, 0, 32'h800, 1, 0, 0));
    vq.push_back(mk(0, 0, 0, 32'h100, 1, 1, 16'h0004, 0, 26'h0, 0, 0,
                    SEL_BR, 0, 32'h114, 1, 0, 0));
    idle(32'h114, 1, 0);  idle(32'h114, 0, 1);
    // PC wraps modulo 2^32.
    vq.push_back(mk(0, 0, 0, 32'h0, 0, 0, 16'h0, 0, 26'h0, 1, 32'hFFFF_FFFC,
                    SEL_JR, 0, 32'hFFFF_FFFC, 1, 0, 0));
    idle(32'hFFFF_FFFC, 1, 0);  idle(32'hFFFF_FFFC, 0, 1);  idle(32'h0, 0, 1);

    foreach (vq[i]) run_vec(vq[i], $sformatf("v%0d", i));

    // Halt mid-FLUSH: frozen, requests ignored, only rst leaves.
    run_vec(mk(0, 0, 0, 0, 0, 0, 16'h0, 1, 26'h40, 0, 0, SEL_J, 0, 32'h100, 1, 0, 0), "h0");
    run_vec(mk(0, 0, 1, 0, 0, 0, 16'h0, 0, 26'h0, 0, 0, SEL_SEQ, 0, 32'h100, 0, 0, 1), "h1");
    run_vec(mk(0, 0, 0, 32'h40, 1, 1, 16'h8, 1, 26'h3, 1, 32'h2001,
               SEL_SEQ, 0, 32'h100, 0, 0, 1), "h2");
    run_vec(mk(0, 1, 0, 0, 0, 0, 16'h0, 0, 26'h0, 0, 0, SEL_SEQ, 0, 32'h100, 0, 0, 1), "h3");
    run_vec(mk(1, 0, 0, 0, 0, 0, 16'h0, 0, 26'h0, 0, 0, SEL_SEQ, 0, 32'h0, 0, 0, 0), "h4");
    run_vec(mk(0, 0, 0, 0, 0, 0, 16'h0, 0, 26'h0, 0, 0, SEL_SEQ, 0, 32'h4, 0, 1, 0), "h5");
    // Halt together with a jump: target loaded, HALT wins the state.
    run_vec(mk(0, 0, 1, 0, 0, 0, 16'h0, 1, 26'h80, 0, 0, SEL_J, 0, 32'h200, 0, 0, 1), "h6");
    run_vec(mk(1, 0, 0, 0, 0, 0, 16'h0, 0, 26'h0, 0, 0, SEL_SEQ, 0, 32'h0, 0, 0, 0), "h7");
    // Halt together with stall from RUN.
    run_vec(mk(0, 1, 1, 0, 0, 0, 16'h0, 0, 26'h0, 0, 0, SEL_SEQ, 0, 32'h0, 0, 0, 1), "h8");
    run_vec(mk(1, 0, 0, 0, 0, 0, 16'h0, 0, 26'h0, 0, 0, SEL_SEQ, 0, 32'h0, 0, 0, 0), "h9");
    run_vec(mk(0, 0, 0, 0, 0, 0, 16'h0, 0, 26'h0, 0, 0, SEL_SEQ, 0, 32'h4, 0, 1, 0), "h10");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
